// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-limited arbiter sharing one async-FIFO write port
// Optional stall counter output enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATASIZE  = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                                      wclk,
  input  logic                                      w_rst,
  input  logic [NREQ-1:0]                           req,
  input  logic [NREQ*DATASIZE-1:0]                  req_data,
  output logic [NREQ-1:0]                           gnt,
  input  logic                                      wfull,
  output logic                                      winc,
  output logic [DATASIZE-1:0]                       wdata,
  output logic                                      busy,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [15:0]                               stall_cnt,
`endif
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [OW-1:0] r_owner, r_last_owner;
  logic [OW-1:0] w_owner_nxt, w_last_nxt, w_pick;
  logic [BW-1:0] r_beat_cnt, w_cnt_nxt;
  logic          w_found, w_own_req, w_beat;

  // Round-robin search starting just after the previous owner, with wrap-around.
  always_comb begin
    logic [OW-1:0] v_idx;
    v_idx   = '0;
    w_pick  = r_last_owner;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = OW'((int'(r_last_owner) + k) % NREQ);
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  assign w_own_req = req[r_owner];
  // Combinational in wfull so a full FIFO is never written.
  assign w_beat    = (r_state == ST_GRANT) && w_own_req && !wfull;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_cnt_nxt   = r_beat_cnt;
    winc        = 1'b0;
    gnt         = '0;
    wdata       = '0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        busy  = 1'b1;
        wdata = req_data[r_owner*DATASIZE +: DATASIZE];
        winc  = w_beat;
        gnt   = w_beat ? (NREQ'(1) << r_owner) : '0;
        if (!w_own_req) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else if (w_beat) begin
          w_cnt_nxt = r_beat_cnt + 1'b1;
          if (r_beat_cnt == BW'(MAX_BURST - 1)) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_owner;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge w_rst) begin
    if (!w_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NREQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_beat_cnt   <= w_cnt_nxt;
    end
  end

  assign owner = r_owner;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge wclk or negedge w_rst) begin
    if (!w_rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_GRANT) && w_own_req && wfull && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized self-checking bench for fifo_wr_arbiter against a queue-based reference model
module tb_fifo_wr_arbiter;

  localparam int DW   = 8;
  localparam int NREQ = 4;
  localparam int MB   = 4;
  localparam int OW   = 2;

  logic               wclk = 1'b0;
  logic               w_rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    gnt;
  logic               wfull = 1'b0;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic               busy;
  logic [OW-1:0]      owner;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]        stall_cnt;
`endif

  fifo_wr_arbiter #(.DATASIZE(DW), .NREQ(NREQ), .MAX_BURST(MB)) dut (
    .wclk(wclk), .w_rst(w_rst), .req(req), .req_data(req_data), .gnt(gnt),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy),
`ifdef FIFO_WR_ARB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .owner(owner)
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Per-producer pending words; req is simply "queue non-empty", data is its head.
  logic [DW-1:0] q [NREQ][$];

  // Reference model: is a burst in progress, who owns it, who owned last, words so far.
  int m_busy, m_owner, m_last, m_cnt;
  int n_busy, n_owner, n_last, n_cnt;
  logic            e_winc;
  logic [NREQ-1:0] e_gnt;
  logic [DW-1:0]   e_wdata;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (q[i].size() > 0);
      req_data[i*DW +: DW] = req[i] ? q[i][0] : '0;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
  endtask

  task automatic model_eval();
    bit found;
    e_winc = 1'b0; e_gnt = '0; e_wdata = '0;
    n_busy = m_busy; n_owner = m_owner; n_last = m_last; n_cnt = m_cnt;
    if (m_busy != 0) begin
      e_wdata = req_data[m_owner*DW +: DW];
      if (req[m_owner] && !wfull) begin
        e_winc = 1'b1;
        e_gnt[m_owner] = 1'b1;
      end
      if (!req[m_owner]) begin
        n_busy = 0; n_last = m_owner;
      end else if (e_winc) begin
        n_cnt = m_cnt + 1;
        if (n_cnt == MB) begin
          n_busy = 0; n_last = m_owner;
        end
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req[(m_last + k) % NREQ]) begin
          found = 1'b1;
          n_owner = (m_last + k) % NREQ;
        end
      end
      n_busy = 1; n_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (e_gnt[i]) void'(q[i].pop_front());
    m_busy = n_busy; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
    drive_inputs();
  endtask

  task automatic do_reset();
    w_rst = 1'b0;
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    drive_inputs();
    model_reset();
    repeat (2) @(posedge wclk);
    #1 w_rst = 1'b1;
  endtask

  task automatic test_reset();
    w_rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      q[i].delete();
      q[i].push_back(8'($urandom));
    end
    drive_inputs();
    model_reset();
    #1;
    checks++;
    if ({winc, gnt, busy, wdata, owner} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got winc=%b gnt=%b busy=%b wdata=%h owner=%0d want all 0",
               winc, gnt, busy, wdata, owner);
    end
    @(posedge wclk);
    #1 w_rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk);
      model_eval();
      checks++;
      if ({winc, gnt, wdata, busy, owner} !== {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]}) begin
        errors++;
        $display("FAIL reset_model c=%0d got=%h want=%h", c,
                 {winc, gnt, wdata, busy, owner}, {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]});
      end
      if (c == 1) begin
        checks++;
        if (owner !== 2'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL reset_first_winner got owner=%0d busy=%b want owner=0 busy=1", owner, busy);
        end
      end
      step();
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] sw [3];
    sw[0] = 8'h11; sw[1] = 8'h22; sw[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) q[0].push_back(sw[i]);
    drive_inputs();
    for (int c = 0; c < 7; c++) begin
      @(negedge wclk);
      model_eval();
      checks++;
      if ({winc, gnt, wdata, busy, owner} !== {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]}) begin
        errors++;
        $display("FAIL single_model c=%0d got=%h want=%h", c,
                 {winc, gnt, wdata, busy, owner}, {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]});
      end
      checks++;
      if (c >= 1 && c <= 3) begin
        if (winc !== 1'b1 || gnt !== 4'b0001 || wdata !== sw[c-1]) begin
          errors++;
          $display("FAIL single_word c=%0d got winc=%b gnt=%b wdata=%h want 1 0001 %h", c, winc, gnt, wdata, sw[c-1]);
        end
      end else if (winc !== 1'b0 || gnt !== '0 || (c >= 5 && busy !== 1'b0)) begin
        errors++;
        $display("FAIL single_idle c=%0d got winc=%b gnt=%b busy=%b want winc=0", c, winc, gnt, busy);
      end
      step();
    end
  endtask

  task automatic test_contention();
    int want, got;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      q[0].push_back(8'($urandom));
      q[1].push_back(8'($urandom));
    end
    drive_inputs();
    for (int c = 0; c < 15; c++) begin
      @(negedge wclk);
      model_eval();
      checks++;
      if ({winc, gnt, wdata, busy, owner} !== {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]}) begin
        errors++;
        $display("FAIL contention_model c=%0d got=%h want=%h", c,
                 {winc, gnt, wdata, busy, owner}, {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]});
      end
      want = (c == 0 || (c - 1) % (MB + 1) == MB) ? -1 : ((c - 1) / (MB + 1)) % 2;
      got  = !winc ? -1 : (gnt == 4'b0001) ? 0 : (gnt == 4'b0010) ? 1 : 9;
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL contention_writer c=%0d got=%0d want=%0d", c, got, want);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int beats, stalls, writes;
    bit stalled;
    beats = 0; stalls = 0; writes = 0; stalled = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) q[2].push_back(8'($urandom));
    drive_inputs();
    for (int c = 0; c < 12; c++) begin
      @(negedge wclk);
      model_eval();
      checks++;
      if ({winc, gnt, wdata, busy, owner} !== {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]}) begin
        errors++;
        $display("FAIL backpressure_model c=%0d got=%h want=%h", c,
                 {winc, gnt, wdata, busy, owner}, {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]});
      end
      if (wfull) begin
        checks++;
        if (winc !== 1'b0 || gnt !== '0 || owner !== 2'd2 || busy !== 1'b1) begin
          errors++;
          $display("FAIL backpressure_hold c=%0d got winc=%b gnt=%b owner=%0d busy=%b want 0 0000 2 1",
                   c, winc, gnt, owner, busy);
        end
      end
      if (winc === 1'b1) writes++;
      if (e_winc) beats++;
      step();
      if (beats == 2 && !stalled) begin
        stalled = 1'b1; wfull = 1'b1; stalls = 3;
      end else if (stalls > 0) begin
        stalls--;
        if (stalls == 0) wfull = 1'b0;
      end
    end
    checks++;
    if (writes != 4) begin
      errors++;
      $display("FAIL backpressure_writes got=%0d want=4", writes);
    end
  endtask

  task automatic test_early_drop();
    int wr [$];
    do_reset();
    q[3].push_back(8'($urandom));
    drive_inputs();
    for (int c = 0; c < 7; c++) begin
      @(negedge wclk);
      model_eval();
      checks++;
      if ({winc, gnt, wdata, busy, owner} !== {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]}) begin
        errors++;
        $display("FAIL early_drop_model c=%0d got=%h want=%h", c,
                 {winc, gnt, wdata, busy, owner}, {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]});
      end
      if (c == 3) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL early_drop_idle got busy=%b want 0", busy);
        end
      end
      if (winc === 1'b1) wr.push_back(int'(owner));
      step();
      if (c == 1) begin
        q[0].push_back(8'($urandom));
        drive_inputs();
      end
    end
    checks++;
    if (wr.size() != 2 || wr[0] != 3 || wr[1] != 0) begin
      errors++;
      $display("FAIL early_drop_order got n=%0d first=%0d second=%0d want n=2 3 0",
               wr.size(), (wr.size() > 0) ? wr[0] : -1, (wr.size() > 1) ? wr[1] : -1);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    bit done;
    beats = 0; done = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q[1].push_back(8'($urandom));
      q[2].push_back(8'($urandom));
    end
    drive_inputs();
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge wclk);
      model_eval();
      if (e_gnt[1]) beats++;
      if (beats == 2) begin
        w_rst = 1'b0;
        #1;
        checks++;
        if (winc !== 1'b0 || busy !== 1'b0 || owner !== 2'd0 || gnt !== '0 || wdata !== '0) begin
          errors++;
          $display("FAIL reset_mid_outputs got winc=%b busy=%b owner=%0d gnt=%b wdata=%h want all 0",
                   winc, busy, owner, gnt, wdata);
        end
        model_reset();
        @(posedge wclk);
        #1 w_rst = 1'b1;
        drive_inputs();
        done = 1'b1;
      end else begin
        step();
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL reset_mid_timeout got beats=%0d want 2", beats);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge wclk);
      model_eval();
      checks++;
      if ({winc, gnt, wdata, busy, owner} !== {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]}) begin
        errors++;
        $display("FAIL reset_mid_model c=%0d got=%h want=%h", c,
                 {winc, gnt, wdata, busy, owner}, {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]});
      end
      if (c == 1) begin
        checks++;
        if (owner !== 2'd1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_winner got owner=%0d busy=%b want 1 1", owner, busy);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0 && q[i].size() < 6) q[i].push_back(8'($urandom));
      end
      wfull = ($urandom_range(0, 3) == 0);
      drive_inputs();
      @(negedge wclk);
      model_eval();
      checks++;
      if ({winc, gnt, wdata, busy, owner} !== {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]}) begin
        errors++;
        $display("FAIL random_model c=%0d got=%h want=%h", c,
                 {winc, gnt, wdata, busy, owner}, {e_winc, e_gnt, e_wdata, m_busy[0], m_owner[OW-1:0]});
      end
      step();
    end
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    q[0].push_back(8'($urandom));
    wfull = 1'b1;
    drive_inputs();
    repeat (6) @(posedge wclk);
    @(negedge wclk);
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stats_five got=%0d want=5", stall_cnt);
    end
    repeat (70000) @(posedge wclk);
    @(negedge wclk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate got=%h want=ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side arbiter for the async FIFO. Shares the single FIFO write port (winc/wdata, back-pressured by wfull) among NREQ producers in the write clock domain.
- Round-robin between requesters. Each grant is a burst-limited lock of up to MAX_BURST words.
- Sits between producer logic and the FIFO write interface; wfull comes from the write-pointer logic.

Parameters:
- DATASIZE, 8, data word width; matches the FIFO data width.
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum words accepted per grant before rotating (1..16).

Ports:
- wclk  in  1  write-domain clock.
- w_rst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; bit i high means req_data slice i is valid.
- req_data  in  NREQ*DATASIZE  requester data; slice i is bits [i*DATASIZE +: DATASIZE].
- gnt  out  NREQ  per-requester accept strobe; gnt[i]=1 means the word was written this cycle.
- wfull  in  1  FIFO full flag from the write-pointer block.
- winc  out  1  FIFO write enable.
- wdata  out  DATASIZE  FIFO write data.
- busy  out  1  arbiter is in GRANT.
- owner  out  $clog2(NREQ)  index of the current/last owner.

Behaviour:
- State machine has two states, IDLE and GRANT. Registers: state, owner, last_owner, beat_cnt ($clog2(MAX_BURST)+1 bits).
- Reset (asynchronous, w_rst=0):
  - state=IDLE, owner=0, last_owner=NREQ-1 (so requester 0 wins first), beat_cnt=0.
  - Outputs: winc=0, gnt=0, busy=0, wdata=0.
- IDLE:
  - No writes; winc=0.
  - If |req, pick the first set bit searching from last_owner+1 upward with wrap-around. Register it into owner, clear beat_cnt, go to GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - beat = req[owner] & ~wfull.
  - winc = beat; gnt = one-hot(owner) & {NREQ{beat}}.
  - wdata = req_data slice[owner], driven whenever in GRANT and 0 in IDLE.
  - winc, gnt and wdata are combinational from registered state/owner plus req and wfull. This gives zero-cycle reaction to wfull, so the FIFO is never written while full.
  - On a beat: beat_cnt += 1.
  - Exit to IDLE and set last_owner=owner when either:
    - req[owner]=0 (no beat that cycle), or
    - a beat occurs with beat_cnt==MAX_BURST-1.
  - While wfull=1 with req[owner]=1: hold ownership, beat_cnt unchanged, no timeout.
- Latency and throughput:
  - First word of a request is accepted no earlier than the 2nd rising edge after req rises (one IDLE arbitration cycle).
  - Sustained throughput is MAX_BURST words per MAX_BURST+1 cycles when contending.
- Requester rules:
  - req and data must stay stable until gnt.
  - req may drop only after gnt, or while not owner.
  - Dropping req while owner ends the burst.
- Simultaneous events:
  - wfull and final-beat conditions resolve as above; wfull suppresses the beat, so the burst does not end.
  - New requests during GRANT wait for the next IDLE.
- Reset mid-burst: all outputs return to reset values immediately. The word in flight that cycle is not written.
- With NREQ=1 the arbiter degenerates correctly: IDLE bubble every MAX_BURST words.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- When defined, add output stall_cnt (16 bits). It counts wclk cycles where state==GRANT & req[owner] & wfull, saturates at 16'hFFFF, and is cleared by w_rst.
- When undefined, the port and counter are absent and functional behaviour is identical.

Test Plan:
- Single requester: req[0] holds 3 words (0x11,0x22,0x33), wfull=0 → first winc 2 cycles after req; wdata 0x11,0x22,0x33 on 3 consecutive cycles; gnt[0] matches winc; then IDLE.
- Contention, MAX_BURST=4: req[0] and req[1] continuous → 4 writes from r0, 1 idle cycle, 4 from r1, 1 idle, then r0 again; owner toggles 0,1,0.
- Back-pressure: wfull=1 for 3 cycles mid-burst after beat 2 of r2 → winc=0 and gnt=0 during those cycles; owner stays 2; remaining 2 beats follow after wfull falls; no write while wfull=1.
- Early drop: r3 owner, req[3] falls after 1 beat → IDLE next cycle, last_owner=3; pending req[0] wins next arbitration.
- Reset mid-burst: w_rst low during beat 2 of r1 → winc=0, busy=0, owner=0 immediately; after release with req[1] and req[2] high, r1 wins first (last_owner=NREQ-1).
- With FIFO_WR_ARB_STATS_EN: 5 stalled cycles → stall_cnt=5; force 70000 stalled cycles → stall_cnt=0xFFFF.
